// File: rtl/centroide_x_if.sv
// Camera pixel stream in, centroid result out.
// The slave modport is the centroid block's view of these signals.
interface centroide_x_if;
    logic        VSYNC;
    logic        HREF;
    logic        pixel_valid;
    logic [15:0] pixel;
    logic [9:0]  centroX;
    logic        centro_valid;
    logic        detectado;

    modport master (
        output VSYNC, HREF, pixel_valid, pixel,
        input  centroX, centro_valid, detectado
    );

    modport slave (
        input  VSYNC, HREF, pixel_valid, pixel,
        output centroX, centro_valid, detectado
    );
endinterface

// File: rtl/centroide_x.sv
// Per-frame horizontal centroid of green marker pixels: accumulate, then restoring divide.
// Optional macro CENTROIDE_MIRROR_EN outputs H_RES-1-q for a mirrored camera.
module centroide_x #(
    parameter int         H_RES      = 640,
    parameter logic [5:0] G_MIN      = 6'd40,
    parameter logic [4:0] RB_MAX     = 5'd12,
    parameter int         MIN_PIXELS = 64
) (
    input  logic          PCLK,
    input  logic          RESET,
    centroide_x_if.slave  bus
);
    typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

    localparam logic [9:0]  XMAX = 10'(H_RES);
    localparam logic [9:0]  XLST = 10'(H_RES - 1);
    localparam logic [27:0] QMAX = 28'(H_RES - 1);
    localparam logic [18:0] CMIN = 19'(MIN_PIXELS);

    state_t      state_q, state_d;
    logic [9:0]  x_q;
    logic        vs_q, edge_q;
    logic [27:0] soma_q;
    logic [18:0] cont_q;
    logic [27:0] dvd_q;
    logic [18:0] dvs_q;
    logic [18:0] rem_q;
    logic [4:0]  it_q;
    logic        skip_q;
    logic [9:0]  centroX_q;
    logic        valid_q, det_q;

    logic        marker;
    logic [28:0] soma_sum;
    logic [27:0] soma_sat;
    logic [18:0] cont_sat;
    logic [19:0] rem_sh, rem_sub;
    logic        ge;
    logic [18:0] rem_nxt;
    logic [9:0]  q_clamp, result;

    always_comb begin
        marker = bus.HREF && !bus.VSYNC && bus.pixel_valid && (x_q < XMAX)
                 && (bus.pixel[10:5] >= G_MIN)
                 && (bus.pixel[15:11] <= RB_MAX)
                 && (bus.pixel[4:0] <= RB_MAX);
        soma_sum = {1'b0, soma_q} + 29'(x_q);
        soma_sat = soma_sum[28] ? '1 : soma_sum[27:0];
        cont_sat = (&cont_q) ? cont_q : cont_q + 19'd1;
        // Remainder is always below the 19-bit divisor, so it fits back in 19 bits.
        rem_sh   = {rem_q, dvd_q[27]};
        ge       = rem_sh >= {1'b0, dvs_q};
        rem_sub  = rem_sh - {1'b0, dvs_q};
        rem_nxt  = ge ? rem_sub[18:0] : rem_sh[18:0];
        q_clamp  = (dvd_q > QMAX) ? XLST : dvd_q[9:0];
`ifdef CENTROIDE_MIRROR_EN
        result   = XLST - q_clamp;
`else
        result   = q_clamp;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (edge_q) state_d = (cont_q < CMIN) ? DONE : DIVIDE;
            DIVIDE:  if (it_q == 5'd27) state_d = DONE;
            DONE:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ACCUM;
            x_q       <= '0;
            vs_q      <= 1'b0;
            edge_q    <= 1'b0;
            soma_q    <= '0;
            cont_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            it_q      <= '0;
            skip_q    <= 1'b0;
            centroX_q <= '0;
            valid_q   <= 1'b0;
            det_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= bus.VSYNC;
            edge_q  <= bus.VSYNC && !vs_q;
            valid_q <= 1'b0;

            if (!bus.HREF)
                x_q <= '0;
            else if (bus.pixel_valid && x_q != XMAX)
                x_q <= x_q + 10'd1;

            case (state_q)
                ACCUM: begin
                    if (edge_q) begin
                        dvd_q  <= soma_q;
                        dvs_q  <= cont_q;
                        rem_q  <= '0;
                        it_q   <= '0;
                        skip_q <= cont_q < CMIN;
                        soma_q <= '0;
                        cont_q <= '0;
                    end else if (marker) begin
                        soma_q <= soma_sat;
                        cont_q <= cont_sat;
                    end
                end
                DIVIDE: begin
                    dvd_q <= {dvd_q[26:0], ge};
                    rem_q <= rem_nxt;
                    it_q  <= it_q + 5'd1;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    if (skip_q) begin
                        det_q <= 1'b0;
                    end else begin
                        det_q     <= 1'b1;
                        centroX_q <= result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.centroX      = centroX_q;
    assign bus.centro_valid = valid_q;
    assign bus.detectado    = det_q;
endmodule

// File: tb/tb_centroide_x.sv
// Directed-vector bench for centroide_x; expected centroids computed by hand.
module tb_centroide_x;
    logic PCLK  = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [15:0] MK  = 16'h07E0; // pure green
    localparam logic [15:0] MKB = 16'h650C; // R=12 G=40 B=12, just a marker
    localparam logic [15:0] NG  = 16'h64EC; // G=39
    localparam logic [15:0] NR  = 16'h6D0C; // R=13
    localparam logic [15:0] NB  = 16'h650D; // B=13
    localparam logic [15:0] BLK = 16'h0000;

    centroide_x_if bus ();
    centroide_x dut (.PCLK(PCLK), .RESET(RESET), .bus(bus.slave));

    always #5 PCLK = ~PCLK;

    function automatic int mir(input int q);
`ifdef CENTROIDE_MIRROR_EN
        return 639 - q;
`else
        return q;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [15:0] p);
        @(negedge PCLK);
        bus.HREF = 1'b1; bus.pixel_valid = 1'b1; bus.pixel = p;
    endtask

    task automatic gap();
        @(negedge PCLK);
        bus.HREF = 1'b1; bus.pixel_valid = 1'b0; bus.pixel = MK;
    endtask

    task automatic eol();
        repeat (2) begin
            @(negedge PCLK);
            bus.HREF = 1'b0; bus.pixel_valid = 1'b0; bus.pixel = BLK;
        end
    endtask

    task automatic frame_end(input string tag, input int exp_lat, input int exp_x, input int exp_det);
        int lat, np;
        @(negedge PCLK);
        bus.HREF = 1'b0; bus.pixel_valid = 1'b0; bus.VSYNC = 1'b1;
        lat = -1; np = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge PCLK); #1;
            if (bus.centro_valid) begin
                np++;
                if (lat < 0) lat = k;
            end
        end
        @(negedge PCLK);
        bus.VSYNC = 1'b0;
        repeat (3) @(negedge PCLK);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_pulses"}, np, 1);
        chk({tag, "_x"}, {22'd0, bus.centroX}, exp_x);
        chk({tag, "_det"}, {31'd0, bus.detectado}, exp_det);
    endtask

    initial begin
        bus.VSYNC = 1'b0; bus.HREF = 1'b0; bus.pixel_valid = 1'b0; bus.pixel = BLK;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_x", {22'd0, bus.centroX}, 0);
        chk("rst_valid", {31'd0, bus.centro_valid}, 0);
        chk("rst_det", {31'd0, bus.detectado}, 0);
        @(negedge PCLK) RESET = 1'b0;
        repeat (3) @(negedge PCLK);

        // Columns 100..199 marker, each pixel followed by a not-valid cycle
        for (int c = 0; c < 200; c++) begin
            px(c >= 100 ? MK : BLK);
            gap();
        end
        eol();
        frame_end("t1", 30, mir(149), 1);

        // Too few markers: skip path, previous centroid held
        for (int c = 0; c < 50; c++) px(MK);
        eol();
        frame_end("t2", 2, mir(149), 0);

        // 32 markers each at columns 0 and 639; everything else just off threshold
        for (int l = 0; l < 32; l++) begin
            for (int c = 0; c < 640; c++) begin
                if (c == 0)        px(MKB);
                else if (c == 639) px(MK);
                else if (c % 3 == 0) px(NG);
                else if (c % 3 == 1) px(NR);
                else                 px(NB);
            end
            eol();
        end
        frame_end("t3", 30, mir(319), 1);

        // Columns past H_RES ignored
        for (int c = 0; c < 700; c++) px((c == 10 || c >= 640) ? MK : BLK);
        eol();
        for (int l = 0; l < 63; l++) begin
            for (int c = 0; c < 11; c++) px(c == 10 ? MK : BLK);
            eol();
        end
        frame_end("t4", 30, mir(10), 1);

        // Mid-frame reset discards column-500 markers
        for (int l = 0; l < 10; l++) begin
            for (int c = 0; c < 501; c++) px(c == 500 ? MK : BLK);
            eol();
        end
        @(negedge PCLK) RESET = 1'b1;
        @(posedge PCLK); #1;
        chk("t5_rst_x", {22'd0, bus.centroX}, 0);
        chk("t5_rst_valid", {31'd0, bus.centro_valid}, 0);
        chk("t5_rst_det", {31'd0, bus.detectado}, 0);
        @(negedge PCLK) RESET = 1'b0;
        for (int l = 0; l < 100; l++) begin
            for (int c = 0; c < 21; c++) px(c == 20 ? MK : BLK);
            eol();
        end
        frame_end("t5", 30, mir(20), 1);

        // All-marker lines across the full width: 319.5 truncates to 319
        for (int l = 0; l < 24; l++) begin
            for (int c = 0; c < 640; c++) px(MK);
            eol();
        end
        frame_end("t6", 30, mir(319), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
